rsdec_chien_ctrl: RTL
=====================

RSDEC_CHIEN_CTRL -- requirements
Module: rsdec_chien_ctrl

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock.
REQ-002 SHALL have: clrn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  in  1  one-cycle request to decode one codeword; sampled only in IDLE.
REQ-004 SHALL have: n_len  in  8  shortened codeword length, 1..255; sampled with start.
REQ-005 SHALL have: deg  in  3  error-locator degree from key-equation solver, 0..5; sampled with start.
REQ-006 SHALL have: coef_req  out  1  high in LOAD; asks the solver for the next lambda/omega coefficient pair.
REQ-007 SHALL have: coef_vld  in  1  solver presents a coefficient pair on the Chien lambda/omega inputs this cycle.
REQ-008 SHALL have: ch_shorten, ch_load, ch_search  out  1 each  Chien-search control strobes.
REQ-009 SHALL have: ch_error  in  8  Chien combinational error magnitude; nonzero = root at current position.
REQ-010 SHALL have: out_valid out 1, out_ready in 1, out_val out 8, out_pos out 8, out_last out 1  correction-stream handshake.
REQ-011 SHALL have: busy out 1, done out 1 (one-cycle pulse), fail out 1, err_cnt out 4.

Function
REQ-012 SHALL implement states IDLE, SHORTEN, LOAD, SEARCH, FLUSH, DONE; busy = state != IDLE.
REQ-013 IDLE: start=1 and n_len!=0 SHALL latch n_len, deg, set skip = 255-n_len, clear err_cnt, and go to SHORTEN if skip>0, else LOAD.
REQ-014 IDLE: start=1 with n_len=0 SHALL go directly to DONE with fail=1; no strobes issued.
REQ-015 start while busy SHALL be ignored.
REQ-016 SHORTEN: ch_shorten=1 for exactly skip consecutive cycles (down-counter), then LOAD.
REQ-017 LOAD: coef_req=1; ch_load = coef_vld; a 3-bit counter SHALL count accepted pairs, and after the 6th accepted pair the state SHALL be SEARCH; coef_vld=0 cycles stall with no strobe.
REQ-018 Coefficient order SHALL be index 5 first, index 0 last.
REQ-019 SEARCH: adv = ~out_valid | out_ready; ch_search = adv; no strobe when adv=0 (Chien state held).
REQ-020 On adv: out_valid<=1, out_val<=ch_error, out_pos<=p, out_last<=(p==n_len-1), p<=p+1; p starts at 0.
REQ-021 On adv with ch_error!=0, err_cnt SHALL increment, saturating at 15.
REQ-022 After the adv with p==n_len-1, state SHALL be FLUSH; no further ch_search.
REQ-023 FLUSH: out_valid held until out_ready=1; on that handshake out_valid<=0 and state DONE.
REQ-024 Outside SEARCH/FLUSH, out_valid SHALL deassert only via an accepted handshake; out_val/out_pos/out_last stable while out_valid=1 and out_ready=0.
REQ-025 DONE: done=1 for one cycle; fail <= (deg>5) | (err_cnt != deg); next state IDLE.
REQ-026 fail and err_cnt SHALL hold from DONE until the next accepted start.
REQ-027 At most one of ch_shorten, ch_load, ch_search SHALL be high in any cycle.
REQ-028 Minimum latency start->done SHALL be skip + 6 + n_len + 2 cycles with coef_vld and out_ready held high.

Reset
REQ-029 clrn=0 SHALL asynchronously force IDLE and all outputs 0 (strobes, coef_req, out_*, busy, done, fail, err_cnt), all counters 0.
REQ-030 Reset mid-operation SHALL abandon the codeword; the Chien block shares clrn.
REQ-031 First start after clrn release SHALL be honoured on the first rising edge with clrn=1.

Verification
REQ-032 n_len=255, deg=2, coef_vld/out_ready=1, roots at p=10,200 -> 0 shorten cycles, 6 load, 255 outputs, out_last at p=254, err_cnt=2, fail=0, done 263 cycles after start.
REQ-033 n_len=204, deg=3, two roots -> ch_shorten exactly 51 cycles, 204 outputs, err_cnt=2, fail=1.
REQ-034 coef_vld toggling 1,0,1,0... in LOAD -> ch_load only when coef_vld=1, exactly 6 pulses, SEARCH entered after 6th.
REQ-035 out_ready low 3 cycles mid-SEARCH at p=40 -> ch_search=0 for those cycles, out_pos=40 and out_val stable, no lost or duplicated position.
REQ-036 start with n_len=0 -> done next cycle+1, fail=1, no strobes; start during SEARCH -> ignored.
REQ-037 clrn pulsed low during SEARCH at p=100 -> all outputs 0 immediately, IDLE; following start runs a full clean decode.

Source files
------------

// File: rtl/rsdec_chien_ctrl.sv
// Sequencer for the Reed-Solomon Chien search: shortening skip, locator/evaluator
// coefficient load, root search with a ready/valid correction stream, and pass/fail.
module rsdec_chien_ctrl (
   input  logic       clk,
   input  logic       clrn,
   input  logic       i_start,
   input  logic [7:0] i_n_len,
   input  logic [2:0] i_deg,
   output logic       o_coef_req_c,
   input  logic       i_coef_vld,
   output logic       o_ch_shorten_c,
   output logic       o_ch_load_c,
   output logic       o_ch_search_c,
   input  logic [7:0] i_ch_error,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output logic [7:0] o_out_val,
   output logic [7:0] o_out_pos,
   output logic       o_out_last,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_fail,
   output logic [3:0] o_err_cnt
);

   localparam int unsigned LEN_W    = 8;
   localparam int unsigned DEG_W    = 3;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned LD_W     = 3;
   localparam int unsigned MAX_DEG  = 5;
   localparam int unsigned NUM_COEF = 6;
   localparam int unsigned FULL_LEN = 255;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SHORTEN = 3'd1,
      S_LOAD    = 3'd2,
      S_SEARCH  = 3'd3,
      S_FLUSH   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [LEN_W-1:0]   r_n_len;
   logic [DEG_W-1:0]   r_deg;
   logic               r_zero_len;
   logic [LEN_W-1:0]   r_skip_cnt;
   logic [LD_W-1:0]    r_ld_cnt;
   logic [LEN_W-1:0]   r_pos;
   logic [CNT_W-1:0]   r_err_cnt;
   logic               r_fail;
   logic               r_busy;
   logic               r_done;
   logic               r_out_valid;
   logic [LEN_W-1:0]   r_out_val;
   logic [LEN_W-1:0]   r_out_pos;
   logic               r_out_last;

   logic               w_adv;
   logic               w_last_pos;
   logic               w_ld_last;
   logic [LEN_W-1:0]   w_skip;
   logic               w_shorten;
   logic               w_load;
   logic               w_search;
   logic               w_coef_req;

   // Stream advances whenever the output register is empty or being drained.
   assign w_adv      = ~r_out_valid | i_out_ready;
   assign w_last_pos = (r_pos == (r_n_len - LEN_W'(1)));
   assign w_ld_last  = (r_ld_cnt == LD_W'(NUM_COEF - 1));
   assign w_skip     = LEN_W'(FULL_LEN) - i_n_len;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_coef_req  = 1'b0;
      w_shorten   = 1'b0;
      w_load      = 1'b0;
      w_search    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (i_n_len == '0)        w_state_nxt = S_DONE;
               else if (w_skip != '0)    w_state_nxt = S_SHORTEN;
               else                      w_state_nxt = S_LOAD;
            end
         end
         S_SHORTEN: begin
            w_shorten = 1'b1;
            if (r_skip_cnt == LEN_W'(1)) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_coef_req = 1'b1;
            w_load     = i_coef_vld;
            if (i_coef_vld && w_ld_last) w_state_nxt = S_SEARCH;
         end
         S_SEARCH: begin
            w_search = w_adv;
            if (w_adv && w_last_pos) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (i_out_ready) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_n_len     <= '0;
         r_deg       <= '0;
         r_zero_len  <= 1'b0;
         r_skip_cnt  <= '0;
         r_ld_cnt    <= '0;
         r_pos       <= '0;
         r_err_cnt   <= '0;
         r_fail      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_val   <= '0;
         r_out_pos   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= (w_state_nxt == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_n_len    <= i_n_len;
                  r_deg      <= i_deg;
                  r_zero_len <= (i_n_len == '0);
                  r_skip_cnt <= w_skip;
                  r_ld_cnt   <= '0;
                  r_pos      <= '0;
                  r_err_cnt  <= '0;
                  r_fail     <= 1'b0;
               end
            end
            S_SHORTEN: begin
               r_skip_cnt <= r_skip_cnt - LEN_W'(1);
            end
            S_LOAD: begin
               if (i_coef_vld) begin
                  r_ld_cnt <= w_ld_last ? '0 : r_ld_cnt + LD_W'(1);
               end
            end
            S_SEARCH: begin
               if (w_adv) begin
                  r_out_valid <= 1'b1;
                  r_out_val   <= i_ch_error;
                  r_out_pos   <= r_pos;
                  r_out_last  <= w_last_pos;
                  r_pos       <= r_pos + LEN_W'(1);
                  // Nonzero magnitude marks a root; count saturates.
                  if ((i_ch_error != '0) && (r_err_cnt != '1)) begin
                     r_err_cnt <= r_err_cnt + CNT_W'(1);
                  end
               end
            end
            S_FLUSH: begin
               if (i_out_ready) r_out_valid <= 1'b0;
            end
            S_DONE: begin
               r_fail <= r_zero_len | (r_deg > DEG_W'(MAX_DEG)) |
                         (r_err_cnt != CNT_W'(r_deg));
            end
            default: begin
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_coef_req_c   = w_coef_req;
   assign o_ch_shorten_c = w_shorten;
   assign o_ch_load_c    = w_load;
   assign o_ch_search_c  = w_search;
   assign o_out_valid    = r_out_valid;
   assign o_out_val      = r_out_val;
   assign o_out_pos      = r_out_pos;
   assign o_out_last     = r_out_last;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_fail         = r_fail;
   assign o_err_cnt      = r_err_cnt;

endmodule
